cluster_clock_gate_ctrl: RTL and testbench
==========================================

Name: cluster_clock_gate_ctrl

Overview:
- Idle-based clock-gating controller for one cluster clock domain.
- Watches activity from NUM_REQ requesters and drives a registered, glitch-free clock enable to the cluster clock gate/buffer stage.
- Gates the clock after a programmable run of idle cycles.
- On a wake-up request, re-enables the clock and holds off grants until the clock has settled.

Parameters:
- NUM_REQ, 4, number of requester/busy lanes.
- IDLE_CNT_W, 8, width of idle counter and threshold.
- WAKE_CYCLES, 2, settle cycles in WAKE before grants resume (>=1).

Ports:
- clk_i  in  1  free-running (ungated) clock.
- rst_i  in  1  asynchronous, active-high reset.
- cfg_enable_i  in  1  1 = automatic gating allowed.
- cfg_idle_thresh_i  in  IDLE_CNT_W  idle cycles counted in IDLE_WAIT before gating.
- req_i  in  NUM_REQ  per-requester clock request (level, held until done).
- busy_i  in  NUM_REQ  per-requester busy/in-flight indication.
- gnt_o  out  NUM_REQ  per-requester grant: gated clock is running and stable.
- clk_en_o  out  1  enable to cluster clock gate; 1 = clock runs.
- gated_o  out  1  status: 1 while in GATED.
- state_o  out  2  RUN=0, IDLE_WAIT=1, GATED=2, WAKE=3.

Behaviour:
- Reset (async, rst_i=1):
  - state=RUN; idle_cnt=0; wake_cnt=0.
  - clk_en_o=1, gnt_o=0, gated_o=0, state_o=0, all immediately.
- activity = |req_i | |busy_i (combinational, sampled each edge).
- RUN:
  - If cfg_enable_i and !activity -> IDLE_WAIT, idle_cnt<=0.
  - Otherwise stay in RUN.
- IDLE_WAIT:
  - If activity or !cfg_enable_i -> RUN, idle_cnt<=0.
  - Else if idle_cnt >= cfg_idle_thresh_i -> GATED.
  - Else idle_cnt<=idle_cnt+1.
  - Threshold is compared live each cycle. idle_cnt never exceeds the threshold, so there is no wrap.
  - cfg_idle_thresh_i=0 gates on the edge after entering IDLE_WAIT.
- GATED:
  - If activity or !cfg_enable_i -> WAKE, wake_cnt<=0.
- WAKE:
  - wake_cnt<=wake_cnt+1.
  - When wake_cnt==WAKE_CYCLES-1 -> RUN.
  - Activity is ignored for transitions; WAKE always completes.
- clk_en_o = !(state==GATED), decoded from a dedicated registered GATED flag (single flop output, no combinational path).
  - Enable drops at the edge entering GATED.
  - Enable rises at the edge entering WAKE.
- gated_o = GATED flag.
- gnt_o[i] is registered: gnt_o[i] <= req_i[i] & (state==RUN).
  - Rise latency: 1 cycle after req in RUN.
  - Fall latency: 1 cycle after req drops.
  - A request arriving in IDLE_WAIT forces RUN, then grants the following edge (2 cycles).
- The FSM leaves RUN only with no activity. Therefore a grant never drops while its request is held.
- Simultaneous events:
  - Activity together with threshold reached in IDLE_WAIT: activity wins -> RUN.
  - cfg_enable_i low together with activity: same transitions; no special case.
- Reset mid-operation (any state) forces RUN with clock enabled. Requesters re-handshake after reset.
- Widths:
  - idle_cnt is IDLE_CNT_W bits.
  - wake_cnt is $clog2(WAKE_CYCLES+1) bits.
  - Comparisons are unsigned.
- WAKE_CYCLES<1 is illegal; elaboration-time assertion.

Test Plan:
- Reset: assert rst_i with req_i=4'b1111 -> clk_en_o=1, gnt_o=0, state_o=0 asynchronously; gnt_o=4'b1111 one edge after release.
- Gating timing: enable=1, thresh=3, activity drops after edge 0 -> IDLE_WAIT at edge 1, idle_cnt 1,2,3 at edges 2-4, GATED and clk_en_o=0 at edge 5.
- Wake: in GATED, WAKE_CYCLES=2, req_i[2]=1 -> WAKE/clk_en_o=1 at edge 1, RUN at edge 3, gnt_o[2]=1 at edge 4; other gnt bits stay 0.
- Abort: thresh=5, busy_i[0] pulses one cycle at idle_cnt=2 -> RUN, idle_cnt=0; next gating occurs a full thresh+2 edges after busy drops.
- Disable: in GATED, drop cfg_enable_i -> WAKE then RUN; with enable low, 50 idle cycles keep state_o=0 and clk_en_o=1. thresh=0 with enable=1 -> GATED two edges after idle.
- Reset mid-GATED: assert rst_i -> clk_en_o=1 and gated_o=0 immediately, no clock edge required.

Source files
------------

// File: rtl/cluster_clock_gate_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cluster_clock_gate_ctrl_if
// Purpose  : Config, requester handshake and gate-control signals of the
//            cluster clock-gating controller.
// Revision : 1.0 - initial release
// ============================================================================
interface cluster_clock_gate_ctrl_if #(
    parameter int NUM_REQ    = 4,
    parameter int IDLE_CNT_W = 8
);
    logic                  cfg_enable_i;
    logic [IDLE_CNT_W-1:0] cfg_idle_thresh_i;
    logic [NUM_REQ-1:0]    req_i;
    logic [NUM_REQ-1:0]    busy_i;
    logic [NUM_REQ-1:0]    gnt_o;
    logic                  clk_en_o;
    logic                  gated_o;
    logic [1:0]            state_o;

    // Controller side
    modport slave (
        input  cfg_enable_i, cfg_idle_thresh_i, req_i, busy_i,
        output gnt_o, clk_en_o, gated_o, state_o
    );

    // Requester / configuration side
    modport master (
        output cfg_enable_i, cfg_idle_thresh_i, req_i, busy_i,
        input  gnt_o, clk_en_o, gated_o, state_o
    );
endinterface
`default_nettype wire

// File: rtl/cluster_clock_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cluster_clock_gate_ctrl
// Purpose  : Idle-based clock-gating controller for one cluster clock domain.
// Revision : 1.0 - initial release
// ============================================================================
module cluster_clock_gate_ctrl #(
    parameter int NUM_REQ     = 4,
    parameter int IDLE_CNT_W  = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    cluster_clock_gate_ctrl_if.slave bus
);

    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam logic [WAKE_W-1:0] c_WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    generate
        if (WAKE_CYCLES < 1) begin : g_param_check
            $error("cluster_clock_gate_ctrl: WAKE_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_IDLE_WAIT = 2'd1,
        ST_GATED     = 2'd2,
        ST_WAKE      = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDLE_CNT_W-1:0] r_idle_cnt;
    logic [IDLE_CNT_W-1:0] w_idle_cnt_nxt;
    logic [WAKE_W-1:0]     r_wake_cnt;
    logic [WAKE_W-1:0]     w_wake_cnt_nxt;
    logic                  r_gated;
    logic                  r_clk_en;
    logic [NUM_REQ-1:0]    r_gnt;
    logic                  w_activity;

    assign w_activity = (|bus.req_i) | (|bus.busy_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_RUN;
            r_idle_cnt <= '0;
            r_wake_cnt <= '0;
            r_gated    <= 1'b0;
            r_clk_en   <= 1'b1;
            r_gnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
            r_wake_cnt <= w_wake_cnt_nxt;
            // Gate flags come straight from the next state so the enable is a
            // bare flop output and cannot glitch.
            r_gated    <= (w_state_nxt == ST_GATED);
            r_clk_en   <= (w_state_nxt != ST_GATED);
            r_gnt      <= bus.req_i & {NUM_REQ{r_state == ST_RUN}};
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idle_cnt_nxt = r_idle_cnt;
        w_wake_cnt_nxt = r_wake_cnt;
        case (r_state)
            ST_RUN: begin
                if (bus.cfg_enable_i && !w_activity) begin
                    w_state_nxt    = ST_IDLE_WAIT;
                    w_idle_cnt_nxt = '0;
                end
            end
            ST_IDLE_WAIT: begin
                // Activity has priority over a threshold hit on the same edge.
                if (w_activity || !bus.cfg_enable_i) begin
                    w_state_nxt    = ST_RUN;
                    w_idle_cnt_nxt = '0;
                end else if (r_idle_cnt >= bus.cfg_idle_thresh_i) begin
                    w_state_nxt = ST_GATED;
                end else begin
                    w_idle_cnt_nxt = r_idle_cnt + 1'b1;
                end
            end
            ST_GATED: begin
                if (w_activity || !bus.cfg_enable_i) begin
                    w_state_nxt    = ST_WAKE;
                    w_wake_cnt_nxt = '0;
                end
            end
            ST_WAKE: begin
                // Settle period always runs to completion regardless of activity.
                w_wake_cnt_nxt = r_wake_cnt + 1'b1;
                if (r_wake_cnt == c_WAKE_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign bus.gnt_o    = r_gnt;
    assign bus.clk_en_o = r_clk_en;
    assign bus.gated_o  = r_gated;
    assign bus.state_o  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cluster_clock_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cluster_clock_gate_ctrl
// Purpose  : Directed + randomized self-checking bench with reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cluster_clock_gate_ctrl;

    localparam int NUM_REQ     = 4;
    localparam int IDLE_CNT_W  = 8;
    localparam int WAKE_CYCLES = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: idle streak length, settle cycles left, gated flag
    int                 m_quiet;
    int                 m_wake_left;
    bit                 m_gated;
    logic [NUM_REQ-1:0] m_gnt;

    always #5 clk = ~clk;

    cluster_clock_gate_ctrl_if #(.NUM_REQ(NUM_REQ), .IDLE_CNT_W(IDLE_CNT_W)) bus ();

    cluster_clock_gate_ctrl #(
        .NUM_REQ    (NUM_REQ),
        .IDLE_CNT_W (IDLE_CNT_W),
        .WAKE_CYCLES(WAKE_CYCLES)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_state();
        if (m_gated)             return 2;
        else if (m_wake_left > 0) return 3;
        else if (m_quiet > 0)    return 1;
        else                     return 0;
    endfunction

    function automatic void model_reset();
        m_quiet     = 0;
        m_wake_left = 0;
        m_gated     = 1'b0;
        m_gnt       = '0;
    endfunction

    function automatic void model_edge();
        bit act;
        bit en;
        int thr;
        act = (|bus.req_i) || (|bus.busy_i);
        en  = bus.cfg_enable_i;
        thr = int'(bus.cfg_idle_thresh_i);
        m_gnt = (m_state() == 0) ? bus.req_i : '0;
        if (m_gated) begin
            if (act || !en) begin
                m_gated     = 1'b0;
                m_wake_left = WAKE_CYCLES;
            end
        end else if (m_wake_left > 0) begin
            m_wake_left--;
        end else if (en && !act) begin
            // quiet-1 idle cycles have been counted once in IDLE_WAIT
            if (m_quiet == 0)           m_quiet = 1;
            else if (m_quiet - 1 >= thr) begin
                m_gated = 1'b1;
                m_quiet = 0;
            end else                    m_quiet++;
        end else begin
            m_quiet = 0;
        end
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".state"}, 32'(bus.state_o), 32'(m_state()));
        check({tag, ".clk_en"}, 32'(bus.clk_en_o), 32'(!m_gated));
        check({tag, ".gated"}, 32'(bus.gated_o), 32'(m_gated));
        check({tag, ".gnt"}, 32'(bus.gnt_o), 32'(m_gnt));
    endtask

    // One clock edge with current inputs; outputs compared on the falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Asynchronous reset applied between edges, checked before any clock edge.
    task automatic reset_pulse(input string tag);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check({tag, ".async_clk_en"}, 32'(bus.clk_en_o), 32'd1);
        check({tag, ".async_gated"}, 32'(bus.gated_o), 32'd0);
        check({tag, ".async_gnt"}, 32'(bus.gnt_o), 32'd0);
        check({tag, ".async_state"}, 32'(bus.state_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_in(input logic en, input int thr, input logic [3:0] req,
                          input logic [3:0] busy);
        bus.cfg_enable_i      = en;
        bus.cfg_idle_thresh_i = IDLE_CNT_W'(thr);
        bus.req_i             = req;
        bus.busy_i            = busy;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        set_in(1'b1, 3, 4'hF, 4'h0);
        @(negedge clk);
        reset_pulse("rst");
        step("rst_rel");
        check("rst_gnt_all", 32'(bus.gnt_o), 32'hF);

        // Gating timing: idle from edge 1, gated at edge 5
        bus.req_i = 4'h0;
        for (int i = 1; i <= 4; i++) step("gate_seq");
        check("gate_edge4_state", 32'(bus.state_o), 32'd1);
        step("gate_seq");
        check("gate_edge5_state", 32'(bus.state_o), 32'd2);
        check("gate_edge5_clk_en", 32'(bus.clk_en_o), 32'd0);

        // Wake on req[2]
        bus.req_i = 4'b0100;
        step("wake");
        check("wake_state", 32'(bus.state_o), 32'd3);
        check("wake_clk_en", 32'(bus.clk_en_o), 32'd1);
        step("wake");
        step("wake");
        check("wake_run", 32'(bus.state_o), 32'd0);
        check("wake_no_gnt_yet", 32'(bus.gnt_o), 32'd0);
        step("wake");
        check("wake_gnt2", 32'(bus.gnt_o), 32'b0100);

        // Abort idle at idle_cnt=2, then full thresh+2 edges to gate
        set_in(1'b1, 5, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) step("abort_pre");
        bus.busy_i = 4'b0001;
        step("abort");
        check("abort_run", 32'(bus.state_o), 32'd0);
        bus.busy_i = 4'b0000;
        for (int i = 0; i < 6; i++) step("abort_post");
        check("abort_not_yet", 32'(bus.gated_o), 32'd0);
        step("abort_post");
        check("abort_gated", 32'(bus.gated_o), 32'd1);

        // Disable while gated, then stay running with enable low
        bus.cfg_enable_i = 1'b0;
        for (int i = 0; i < 3; i++) step("disable");
        check("disable_run", 32'(bus.state_o), 32'd0);
        for (int i = 0; i < 50; i++) step("disable_hold");
        check("disable_clk_en", 32'(bus.clk_en_o), 32'd1);

        // Zero threshold gates two edges after idle
        set_in(1'b1, 0, 4'h0, 4'h0);
        step("thr0");
        step("thr0");
        check("thr0_gated", 32'(bus.state_o), 32'd2);

        reset_pulse("rst_gated");

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0)      bus.req_i  = 4'($urandom);
            else if ($urandom_range(0, 3) == 0) bus.req_i  = 4'h0;
            if ($urandom_range(0, 7) == 0)      bus.busy_i = 4'($urandom);
            else if ($urandom_range(0, 2) == 0) bus.busy_i = 4'h0;
            if ($urandom_range(0, 15) == 0)     bus.cfg_enable_i = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0)     bus.cfg_idle_thresh_i = IDLE_CNT_W'($urandom_range(0, 6));
            if ($urandom_range(0, 299) == 0)    reset_pulse("rnd_rst");
            else                                step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
